ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//   Two-port round-robin arbiter and sequencer for the 8x8 single-port synchronous RAM.
//   Two requesters issue read/write commands via req/ack; block serialises them and drives the RAM.
//   RAM model: one op per posedge; writeEn=1 writes dIn, writeEn=0 registers mem[adr] onto dOut.
//   Sits between requester logic and the RAM instance; sole driver of the RAM inputs.
// PARAMETERS
//   DATA_W  8  data width; must match RAM dIn/dOut
//   ADDR_W  3  address width; must match RAM adr (8 words)
// PORTS
//   clk         in   1       system clock; all state changes on posedge
//   rstN        in   1       asynchronous active-low reset
//   req0/req1   in   1       requester N command valid; held high until ackN seen
//   we0/we1     in   1       1 = write, 0 = read; stable while reqN high
//   adr0/adr1   in   ADDR_W  RAM address; stable while reqN high
//   wdata0/1    in   DATA_W  write data; stable while reqN high
//   ack0/ack1   out  1       one-cycle pulse: command N complete
//   rdata0/1    out  DATA_W  read result for requester N; holds until next read by N
//   rvalid0/1   out  1       one-cycle pulse with ackN when command was a read
//   busy        out  1       high whenever state != IDLE
//   ramAdr      out  ADDR_W  to RAM adr (registered)
//   ramDIn      out  DATA_W  to RAM dIn (registered)
//   ramWriteEn  out  1       to RAM writeEn (registered)
//   ramDOut     in   DATA_W  from RAM dOut
// BEHAVIOUR
//   Reset (async, rstN=0): state=IDLE; ack*, rvalid*, busy, ramWriteEn=0; ramAdr, ramDIn, rdata*=0;
//     lastGrant=1 (so requester 0 wins first tie). Command in flight discarded, no ack.
//   FSM states: IDLE -> ACCESS -> CAPTURE -> ACK -> IDLE; each non-IDLE state lasts exactly 1 cycle.
//   IDLE: if no req, stay; ramWriteEn=0. Else choose winner:
//     only one req high -> that one; both high -> requester != lastGrant.
//     At edge E0: latch grant, lastGrant=winner, ramAdr=adrW, ramDIn=wdataW, ramWriteEn=weW; ->ACCESS.
//   ACCESS: RAM executes op at edge E1. At E1: ramWriteEn=0; ->CAPTURE.
//   CAPTURE: at E2: if read, rdataW=ramDOut, rvalidW=1; ackW=1; ->ACK.
//   ACK: ackW/rvalidW high this cycle only; at E3 cleared; ->IDLE.
//   Requester sees ackN at E3 and may drop or replace its command at E3; IDLE samples no earlier than E4.
//   Latency: req sampled at E0 -> ack high during [E2,E3]; throughput one command per 4 cycles.
//   Write of same address then read (either requester) returns new data (ops strictly serialised).
//   req changing while not IDLE is ignored; only the latched command executes.
//   Losing requester keeps req high and is granted on the next IDLE decision (no starvation).
//   ramWriteEn is high in exactly one cycle (ACCESS) per write; never high in IDLE/CAPTURE/ACK.
//   Reset during ACCESS of a write clears ramWriteEn asynchronously before E1: no RAM write occurs.
//   ack0 and ack1 never high in the same cycle; rvalidN implies ackN.
// TESTING
//   Reset: hold rstN=0, toggle clk -> all outputs 0, busy=0, ramWriteEn=0.
//   req0 we0=1 adr0=5 wdata0=0xA5 -> ramWriteEn=1 one cycle with ramAdr=5/ramDIn=0xA5; ack0 pulse 2 edges later; rvalid0=0.
//   Then req0 we0=0 adr0=5 -> ack0 and rvalid0 pulse together with rdata0=0xA5; ramWriteEn stays 0.
//   req0 and req1 both high continuously (distinct reads) -> grants 0,1,0,1; ack pulses alternate, 4 cycles apart.
//   req1 write adr=2 0x3C, rstN low mid-ACCESS -> ramWriteEn drops at once, no ack1; later read of adr 2 != 0x3C.
//   req1 write adr=7 0x11 then req0 read adr=7 -> rdata0=0x11, rdata1 unchanged.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter that serialises two requesters' read/write commands
// onto a single-port synchronous RAM, one command every four cycles.
module ram_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] adr0_i,
    input  logic [ADDR_W-1:0] adr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] ram_adr_o,
    output logic [DATA_W-1:0] ram_din_o,
    output logic              ram_write_en_o,
    input  logic [DATA_W-1:0] ram_dout_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic                wr_q, wr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [1:0]          ack_q, ack_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                win;

    // On a tie the requester that did not win last time gets the grant
    assign win = (req0_i && req1_i) ? ~last_q : req1_i;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        wr_d     = wr_q;
        we_d     = 1'b0;
        adr_d    = adr_q;
        din_d    = din_q;
        ack_d    = 2'b00;
        rvalid_d = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    state_d = ACCESS;
                    grant_d = win;
                    last_d  = win;
                    wr_d    = win ? we1_i : we0_i;
                    we_d    = win ? we1_i : we0_i;
                    adr_d   = win ? adr1_i : adr0_i;
                    din_d   = win ? wdata1_i : wdata0_i;
                end
            end
            ACCESS: state_d = CAPTURE;
            CAPTURE: begin
                state_d  = ACK;
                ack_d    = {grant_q, ~grant_q};
                rvalid_d = {grant_q, ~grant_q} & {2{~wr_q}};
                rdata0_d = (!wr_q && !grant_q) ? ram_dout_i : rdata0_q;
                rdata1_d = (!wr_q && grant_q) ? ram_dout_i : rdata1_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            din_q    <= '0;
            ack_q    <= 2'b00;
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            din_q    <= din_d;
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign ack0_o         = ack_q[0];
    assign ack1_o         = ack_q[1];
    assign rvalid0_o      = rvalid_q[0];
    assign rvalid1_o      = rvalid_q[1];
    assign rdata0_o       = rdata0_q;
    assign rdata1_o       = rdata1_q;
    assign busy_o         = state_q != IDLE;
    assign ram_adr_o      = adr_q;
    assign ram_din_o      = din_q;
    assign ram_write_en_o = we_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus against a transaction-level model of the arbiter plus a RAM model.
module tb_ram_arbiter;
    logic       clk = 0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [2:0] adr0, adr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, rvalid0, rvalid1, busy, ram_we;
    logic [7:0] rdata0, rdata1, ram_din, ram_dout;
    logic [2:0] ram_adr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .adr0_i(adr0), .adr1_i(adr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
        .rvalid0_o(rvalid0), .rvalid1_o(rvalid1), .busy_o(busy),
        .ram_adr_o(ram_adr), .ram_din_o(ram_din), .ram_write_en_o(ram_we),
        .ram_dout_i(ram_dout)
    );

    // Single-port synchronous RAM, zero-filled on the first edge
    logic [7:0] mem [8];
    bit         ram_init = 0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
            ram_init <= 1;
        end else if (ram_we) mem[ram_adr] <= ram_din;
        else ram_dout <= mem[ram_adr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: ph = cycles since the grant edge, -1 when nothing is in flight
    int         ph;
    bit         mg, mwr, mlast, minit = 0;
    logic [2:0] madr;
    logic [7:0] mdin;
    logic [7:0] mmem [8];
    logic [7:0] mrd [2];
    always @(posedge clk or negedge rst_n) begin
        if (!minit) begin
            for (int i = 0; i < 8; i++) mmem[i] = 8'h00;
            minit = 1;
        end
        if (!rst_n) begin
            ph = -1; mlast = 1; madr = 0; mdin = 0; mrd[0] = 0; mrd[1] = 0; mg = 0; mwr = 0;
        end else if (ph == -1) begin
            if (req0 || req1) begin
                mg    = (req0 && req1) ? !mlast : req1;
                mlast = mg;
                mwr   = mg ? we1 : we0;
                madr  = mg ? adr1 : adr0;
                mdin  = mg ? wdata1 : wdata0;
                ph    = 0;
            end
        end else if (ph == 0) begin
            if (mwr) mmem[madr] = mdin;
            ph = 1;
        end else if (ph == 1) begin
            if (!mwr) mrd[mg] = mmem[madr];
            ph = 2;
        end else ph = -1;
    end

    always @(negedge clk) begin
        chk("ack0", ack0, ph == 2 && !mg);
        chk("ack1", ack1, ph == 2 && mg);
        chk("rvalid0", rvalid0, ph == 2 && !mg && !mwr);
        chk("rvalid1", rvalid1, ph == 2 && mg && !mwr);
        chk("busy", busy, ph != -1);
        chk("ram_we", ram_we, ph == 0 && mwr);
        chk("ram_adr", ram_adr, madr);
        chk("ram_din", ram_din, mdin);
        chk("rdata0", rdata0, mrd[0]);
        chk("rdata1", rdata1, mrd[1]);
    end

    int         we_cnt;
    logic [2:0] we_adr;
    logic [7:0] we_din;
    always @(negedge clk) if (ram_we) begin
        we_cnt++; we_adr = ram_adr; we_din = ram_din;
    end

    task automatic cmd(input bit r, input bit w, input logic [2:0] a, input logic [7:0] d,
                       output int lat, output bit rv);
        if (r) begin req1 = 1; we1 = w; adr1 = a; wdata1 = d; end
        else begin req0 = 1; we0 = w; adr0 = a; wdata0 = d; end
        lat = -1; rv = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (r ? ack1 : ack0) begin
                lat = i; rv = r ? rvalid1 : rvalid0;
                break;
            end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL cmd_timeout: requester %0d got no ack, expected ack within 12 cycles", r);
        end
        @(posedge clk); #1;
        if (r) req1 = 0; else req0 = 0;
    endtask

    int lat, n;
    bit rv;
    int order [4];
    int t [4];

    initial begin
        rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        adr0 = 0; adr1 = 0; wdata0 = 0; wdata1 = 0; we_cnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_ack", {ack0, ack1, rvalid0, rvalid1}, 0);
        chk("rst_rdata", {rdata0, rdata1, ram_din}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        we_cnt = 0;
        cmd(0, 1, 5, 8'hA5, lat, rv);
        chk("wr_lat", lat, 4);
        chk("wr_rvalid", rv, 0);
        chk("wr_we_cycles", we_cnt, 1);
        chk("wr_we_adr", we_adr, 5);
        chk("wr_we_din", we_din, 8'hA5);

        we_cnt = 0;
        cmd(0, 0, 5, 8'h00, lat, rv);
        chk("rd_rvalid", rv, 1);
        chk("rd_rdata0", rdata0, 8'hA5);
        chk("rd_we_cycles", we_cnt, 0);

        @(negedge clk) rst_n = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        req0 = 1; we0 = 0; adr0 = 5; req1 = 1; we1 = 0; adr1 = 3;
        n = 0;
        for (int i = 0; i < 4; i++) begin order[i] = -1; t[i] = 0; end
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin order[n] = ack1 ? 1 : 0; t[n] = i; n++; end
        end
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        chk("rr_count", n, 4);
        chk("rr_g0", order[0], 0);
        chk("rr_g1", order[1], 1);
        chk("rr_g2", order[2], 0);
        chk("rr_g3", order[3], 1);
        chk("rr_gap1", t[1] - t[0], 4);
        chk("rr_gap3", t[3] - t[2], 4);
        chk("rr_rdata0", rdata0, 8'hA5);
        chk("rr_rdata1", rdata1, 8'h00);

        req1 = 1; we1 = 1; adr1 = 2; wdata1 = 8'h3C;
        repeat (2) @(negedge clk);
        chk("abort_we_before", ram_we, 1);
        #2 rst_n = 0;
        #1 chk("abort_we_after", ram_we, 0);
        chk("abort_busy", busy, 0);
        req1 = 0;
        @(negedge clk);
        chk("abort_no_ack", ack1, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        chk("abort_mem", mem[2] == 8'h3C, 0);
        cmd(0, 0, 2, 8'h00, lat, rv);
        chk("abort_rdata0", rdata0, 8'h00);

        cmd(1, 0, 5, 8'h00, lat, rv);
        chk("x_rdata1_pre", rdata1, 8'hA5);
        cmd(1, 1, 7, 8'h11, lat, rv);
        cmd(0, 0, 7, 8'h00, lat, rv);
        chk("x_rdata0", rdata0, 8'h11);
        chk("x_rdata1_kept", rdata1, 8'hA5);
        chk("x_rvalid0", rv, 1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
